// File: rtl/hub75_multichain_driver.sv
// hub75_multichain_driver: BCM scan driver for N_CHAINS parallel HUB75 chains.
// Optional checkerboard source: define HUB75_TEST_PATTERN_EN (adds ctrl_test_pattern).
//
// Ports:
//   clk, ctrl_rst (sync, active high), ctrl_en
//   ctrl_n_rows/n_cols/bitdepth/lsb_blank/brightness : config, clamped and
//     latched on leaving IDLE and at each frame boundary
//   ctrl_swap_req/ack, ctrl_frame_done : frame-synchronous buffer swap
//   mem_en/buffer/addr/bit, mem_din   : frame buffer read port (1-cycle latency)
//   disp_clk/blank/latch/addr/rgb     : panel connector outputs
module hub75_multichain_driver #(
  parameter int N_CHAINS       = 2,
  parameter int N_ROWS_MAX     = 64,
  parameter int N_COLS_MAX     = 256,
  parameter int BITDEPTH_MAX   = 8,
  parameter int CTRL_REG_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = $clog2(N_ROWS_MAX*N_COLS_MAX)-1,
  parameter int ROW_ADDR_WIDTH = $clog2(N_ROWS_MAX)-1
) (
  input  logic                          clk,
  input  logic                          ctrl_rst,
  input  logic                          ctrl_en,
  input  logic [CTRL_REG_WIDTH-1:0]     ctrl_n_rows,
  input  logic [CTRL_REG_WIDTH-1:0]     ctrl_n_cols,
  input  logic [CTRL_REG_WIDTH-1:0]     ctrl_bitdepth,
  input  logic [CTRL_REG_WIDTH-1:0]     ctrl_lsb_blank,
  input  logic [CTRL_REG_WIDTH-1:0]     ctrl_brightness,
`ifdef HUB75_TEST_PATTERN_EN
  input  logic                          ctrl_test_pattern,
`endif
  input  logic                          ctrl_swap_req,
  output logic                          ctrl_swap_ack,
  output logic                          ctrl_frame_done,
  output logic                          mem_en,
  output logic                          mem_buffer,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
  output logic [$clog2(BITDEPTH_MAX)-1:0] mem_bit,
  input  logic [6*N_CHAINS-1:0]         mem_din,
  output logic                          disp_clk,
  output logic                          disp_blank,
  output logic                          disp_latch,
  output logic [ROW_ADDR_WIDTH-1:0]     disp_addr,
  output logic [6*N_CHAINS-1:0]         disp_rgb
);

  localparam int SROWS = N_ROWS_MAX / 2;
  localparam int NR_W  = $clog2(SROWS + 1);
  localparam int NC_W  = $clog2(N_COLS_MAX + 1);
  localparam int BD_W  = $clog2(BITDEPTH_MAX + 1);
  localparam int BIT_W = $clog2(BITDEPTH_MAX);
  localparam int RGB_W = 6 * N_CHAINS;
  localparam int CW    = CTRL_REG_WIDTH;
  localparam int EXT_W = CW + BITDEPTH_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT_ON,
    S_LATCH,
    S_ON
  } state_t;

  state_t r_state;

  logic [NR_W-1:0]           r_n_rows;
  logic [NC_W-1:0]           r_n_cols;
  logic [BD_W-1:0]           r_bitdepth;
  logic [CW-1:0]             r_lsb;
  logic [CW-1:0]             r_bright;

  logic [ROW_ADDR_WIDTH-1:0] r_row;
  logic [BIT_W-1:0]          r_bit;
  logic [NC_W-1:0]           r_col;
  logic [MEM_ADDR_WIDTH-1:0] r_base;
  logic                      r_phase;
  logic                      r_stop;
  logic                      r_rd;
  logic                      r_cap;
  logic [CW-1:0]             r_on_cnt;

  logic                      r_swap_ack;
  logic                      r_frame_done;
  logic                      r_mem_en;
  logic                      r_mem_buffer;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
  logic [BIT_W-1:0]          r_mem_bit;
  logic                      r_disp_clk;
  logic                      r_disp_blank;
  logic                      r_disp_latch;
  logic [ROW_ADDR_WIDTH-1:0] r_disp_addr;
  logic [RGB_W-1:0]          r_disp_rgb;

  logic [NR_W-1:0]  w_nrows_c;
  logic [NC_W-1:0]  w_ncols_c;
  logic [BD_W-1:0]  w_bd_c;
  logic             w_cfg_ok;
  logic [EXT_W-1:0] w_sh_ext;
  logic [CW-1:0]    w_sh;
  logic [CW-1:0]    w_dim;
  logic [CW-1:0]    w_on;
  logic             w_last_bit;
  logic             w_last_row;
  logic             w_frame_end;
  logic             w_col_end;
  logic [RGB_W-1:0] w_pix;
  logic             w_rd_en;

  assign w_nrows_c = (ctrl_n_rows > CW'(SROWS)) ?
                     NR_W'(SROWS) : ctrl_n_rows[NR_W-1:0];
  assign w_ncols_c = (ctrl_n_cols > CW'(N_COLS_MAX)) ?
                     NC_W'(N_COLS_MAX) : ctrl_n_cols[NC_W-1:0];
  assign w_bd_c    = (ctrl_bitdepth > CW'(BITDEPTH_MAX)) ?
                     BD_W'(BITDEPTH_MAX) : ctrl_bitdepth[BD_W-1:0];
  assign w_cfg_ok  = (w_nrows_c != '0) && (w_ncols_c != '0) &&
                     (w_bd_c != '0);

  // On-time: lsb << bit saturating at CW bits, then dimmed, floor of 1.
  always_comb begin
    w_sh_ext = {{BITDEPTH_MAX{1'b0}}, r_lsb} << r_bit;
    w_sh     = (|w_sh_ext[EXT_W-1:CW]) ? '1 : w_sh_ext[CW-1:0];
    w_dim    = w_sh >> r_bright;
    w_on     = (w_dim == '0) ? CW'(1) : w_dim;
  end

  assign w_last_bit  = (BD_W'(r_bit) == r_bitdepth - BD_W'(1));
  assign w_last_row  = (NR_W'(r_row) == r_n_rows - NR_W'(1));
  assign w_frame_end = w_last_bit && w_last_row;
  assign w_col_end   = (r_col == r_n_cols);

`ifdef HUB75_TEST_PATTERN_EN
  logic r_rd_c0;
  assign w_pix   = ctrl_test_pattern ?
                   {RGB_W{r_rd_c0 ^ r_row[0]}} : mem_din;
  assign w_rd_en = ~ctrl_test_pattern;
`else
  assign w_pix   = mem_din;
  assign w_rd_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (ctrl_rst) begin
      r_state      <= S_IDLE;
      r_n_rows     <= '0;
      r_n_cols     <= '0;
      r_bitdepth   <= '0;
      r_lsb        <= '0;
      r_bright     <= '0;
      r_row        <= '0;
      r_bit        <= '0;
      r_col        <= '0;
      r_base       <= '0;
      r_phase      <= 1'b0;
      r_stop       <= 1'b0;
      r_rd         <= 1'b0;
      r_cap        <= 1'b0;
      r_on_cnt     <= '0;
      r_swap_ack   <= 1'b0;
      r_frame_done <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_buffer <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_bit    <= '0;
      r_disp_clk   <= 1'b0;
      r_disp_blank <= 1'b1;
      r_disp_latch <= 1'b0;
      r_disp_addr  <= '0;
      r_disp_rgb   <= '0;
    end else begin
      r_swap_ack   <= 1'b0;
      r_frame_done <= 1'b0;
      r_mem_en     <= 1'b0;
      r_rd         <= 1'b0;
      // Read data arrives one cycle after the read cycle.
      r_cap        <= r_rd;
      if (r_cap) r_disp_rgb <= w_pix;

      // Running on-time of the last latched plane; panel goes dark at 0.
      if (r_on_cnt > CW'(1)) begin
        r_on_cnt <= r_on_cnt - CW'(1);
      end else if (r_on_cnt == CW'(1)) begin
        r_on_cnt     <= '0;
        r_disp_blank <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          r_disp_blank <= 1'b1;
          r_disp_clk   <= 1'b0;
          r_disp_latch <= 1'b0;
          if (ctrl_en && w_cfg_ok) begin
            r_n_rows   <= w_nrows_c;
            r_n_cols   <= w_ncols_c;
            r_bitdepth <= w_bd_c;
            r_lsb      <= ctrl_lsb_blank;
            r_bright   <= ctrl_brightness;
            r_row      <= '0;
            r_bit      <= '0;
            r_col      <= '0;
            r_base     <= '0;
            r_phase    <= 1'b0;
            r_stop     <= 1'b0;
            r_state    <= S_SHIFT;
          end
        end

        // Phase A issues a read, phase B raises disp_clk for the column
        // captured one step earlier, so rgb changes on the falling edge.
        // One trailing A/B pair clocks the final column.
        S_SHIFT: begin
          r_phase <= ~r_phase;
          if (!r_phase) begin
            r_disp_clk <= 1'b0;
            if (!w_col_end) begin
              r_rd       <= 1'b1;
              r_mem_en   <= w_rd_en;
              r_mem_addr <= r_base + MEM_ADDR_WIDTH'(r_col);
              r_mem_bit  <= r_bit;
`ifdef HUB75_TEST_PATTERN_EN
              r_rd_c0    <= r_col[0];
`endif
            end
          end else begin
            r_disp_clk <= (r_col != '0);
            if (w_col_end) begin
              r_col   <= '0;
              r_state <= S_WAIT_ON;
            end else begin
              r_col <= r_col + NC_W'(1);
            end
          end
        end

        S_WAIT_ON: begin
          r_disp_clk <= 1'b0;
          if (r_on_cnt == '0) begin
            r_state <= r_stop ? S_IDLE : S_LATCH;
          end
        end

        S_LATCH: begin
          r_phase <= ~r_phase;
          if (!r_phase) begin
            r_disp_blank <= 1'b1;
          end else begin
            r_disp_latch <= 1'b1;
            r_disp_addr  <= r_row;
            r_state      <= S_ON;
          end
        end

        S_ON: begin
          r_disp_latch <= 1'b0;
          r_disp_blank <= 1'b0;
          r_on_cnt     <= w_on;
          if (w_frame_end) begin
            r_frame_done <= 1'b1;
            if (ctrl_swap_req) begin
              r_mem_buffer <= ~r_mem_buffer;
              r_swap_ack   <= 1'b1;
            end
            r_n_rows   <= w_nrows_c;
            r_n_cols   <= w_ncols_c;
            r_bitdepth <= w_bd_c;
            r_lsb      <= ctrl_lsb_blank;
            r_bright   <= ctrl_brightness;
            r_row      <= '0;
            r_bit      <= '0;
            r_base     <= '0;
          end else if (w_last_bit) begin
            r_bit  <= '0;
            r_row  <= r_row + ROW_ADDR_WIDTH'(1);
            r_base <= r_base + MEM_ADDR_WIDTH'(r_n_cols);
          end else begin
            r_bit <= r_bit + BIT_W'(1);
          end
          // Let this plane's on-time run out before parking in IDLE.
          if (!ctrl_en || (w_frame_end && !w_cfg_ok)) begin
            r_stop  <= 1'b1;
            r_state <= S_WAIT_ON;
          end else begin
            r_state <= S_SHIFT;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ctrl_swap_ack   = r_swap_ack;
  assign ctrl_frame_done = r_frame_done;
  assign mem_en          = r_mem_en;
  assign mem_buffer      = r_mem_buffer;
  assign mem_addr        = r_mem_addr;
  assign mem_bit         = r_mem_bit;
  assign disp_clk        = r_disp_clk;
  assign disp_blank      = r_disp_blank;
  assign disp_latch      = r_disp_latch;
  assign disp_addr       = r_disp_addr;
  assign disp_rgb        = r_disp_rgb;

endmodule
